// File: rtl/regdisp_scanner.sv
// Register-file diagnostic reader: steps dispSel with next/prev, captures
// dispDat into a shadow register and scans it onto an 8-digit 7-seg display.
module regdisp_scanner #(
  parameter int DIGIT_DIV  = 1000,
  parameter int SETTLE_CYC = 2
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        next,
  input  logic        prev,
  input  logic        freeze,
  output logic [4:0]  dispSel,
  input  logic [31:0] dispDat,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic [31:0] shown
);

  localparam int DW = $clog2(DIGIT_DIV);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIGIT_DIV - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic {SETTLE, DISPLAY} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [4:0]    sel_q, sel_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    digit_q, digit_d;
  logic          next_q, prev_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          nx, pv, frame_end;
  logic [31:0]   sh_nib;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    div_d    = div_q + 1'b1;
    digit_d  = digit_q;
    nx       = next & ~next_q;
    pv       = prev & ~prev_q;
    frame_end = (div_q == DIV_LAST) && (digit_q == 3'd7);

    if (div_q == DIV_LAST) begin
      div_d   = '0;
      digit_d = digit_q + 3'd1;
    end

    case (state_q)
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_LAST) begin
          shadow_d = dispDat;
          state_d  = DISPLAY;
        end
      end
      DISPLAY: begin
        if (frame_end && !freeze) shadow_d = dispDat;
      end
      default: state_d = SETTLE;
    endcase

    // A selection change makes any dispDat sample this cycle stale
    if (nx ^ pv) begin
      sel_d    = nx ? sel_q + 5'd1 : sel_q - 5'd1;
      state_d  = SETTLE;
      cnt_d    = '0;
      shadow_d = shadow_q;
    end

    an_d   = ~(8'd1 << digit_q);
    sh_nib = shadow_q >> {digit_q, 2'b00};
    case (sh_nib[3:0])
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      div_q    <= '0;
      digit_q  <= '0;
      next_q   <= 1'b0;
      prev_q   <= 1'b0;
      an_q     <= 8'hFE;
      seg_q    <= 7'b1000000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      digit_q  <= digit_d;
      next_q   <= next;
      prev_q   <= prev;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign dispSel = sel_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign shown   = shadow_q;

endmodule

// File: tb/tb_regdisp_scanner.sv
// Bench for regdisp_scanner: directed scenarios plus random button traffic
// against a cycle-count based reference model.
module tb_regdisp_scanner;
  localparam int DIV = 4;
  localparam int SC  = 2;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        next = 1'b0;
  logic        prev = 1'b0;
  logic        freeze = 1'b0;
  logic [4:0]  dispSel;
  logic [31:0] dispDat;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] shown;
  logic        ovr = 1'b0;
  logic [31:0] ovr_val = 32'hDEAD_BEEF;

  int n_chk = 0;
  int n_err = 0;

  regdisp_scanner #(.DIGIT_DIV(DIV), .SETTLE_CYC(SC)) dut (
    .Clk(Clk), .reset(reset), .next(next), .prev(prev),
    .freeze(freeze), .dispSel(dispSel), .dispDat(dispDat),
    .an(an), .seg(seg), .shown(shown)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] proc_dat(
    logic [4:0] s, logic o, logic [31:0] ov);
    if (o && s == 5'd3) return ov;
    return 32'h1000_0000 + 32'(s) * 32'h11;
  endfunction

  assign dispDat = proc_dat(dispSel, ovr, ovr_val);

  function automatic logic [6:0] hex7(logic [3:0] h);
    logic [6:0] t [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[h];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: scan position derived from cycles since reset,
  // settle tracked as cycles remaining before capture.
  int          t_cyc;
  int          m_settle;
  logic [4:0]  m_sel;
  logic [31:0] m_sh;
  logic        m_np, m_pp;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  bit          mon_en = 0;
  int          dig;
  bit          fe, nx, pv;
  logic [31:0] dat;

  always @(posedge Clk) begin
    if (reset) begin
      t_cyc = 0; m_settle = SC; m_sel = 0; m_sh = 0;
      m_an = 8'hFE; m_seg = 7'b1000000;
    end else begin
      dig = (t_cyc / DIV) % 8;
      fe  = (t_cyc % (8 * DIV)) == 8 * DIV - 1;
      nx  = next && !m_np;
      pv  = prev && !m_pp;
      dat = proc_dat(m_sel, ovr, ovr_val);
      m_an  = ~(8'd1 << dig);
      m_seg = hex7(m_sh[dig*4 +: 4]);
      if (nx != pv) begin
        m_sel = nx ? m_sel + 5'd1 : m_sel - 5'd1;
        m_settle = SC;
      end else if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) m_sh = dat;
      end else if (fe && !freeze) begin
        m_sh = dat;
      end
      t_cyc++;
    end
    m_np = reset ? 1'b0 : next;
    m_pp = reset ? 1'b0 : prev;
    mon_en = 1;
  end

  always @(negedge Clk) begin
    if (mon_en) begin
      chk("sel", 32'(dispSel), 32'(m_sel));
      chk("an", 32'(an), 32'(m_an));
      chk("seg", 32'(seg), 32'(m_seg));
      chk("shown", shown, m_sh);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_next();
    next = 1; cyc(2); next = 0; cyc(2);
  endtask

  task automatic pulse_prev();
    prev = 1; cyc(2); prev = 0; cyc(2);
  endtask

  logic [6:0] beef_seg [8] = '{
    7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011,
    7'b0100001, 7'b0001000, 7'b0000110, 7'b0100001};

  initial begin
    reset = 1; cyc(2);
    reset = 0;
    chk("rst_sel", 32'(dispSel), 32'd0);
    chk("rst_an", 32'(an), 32'hFE);
    chk("rst_seg", 32'(seg), 32'h40);
    cyc(2);
    chk("first_cap", shown, 32'h1000_0000);

    repeat (3) pulse_next();
    chk("next3_sel", 32'(dispSel), 32'd3);
    chk("next3_shown", shown, 32'h1000_0033);

    repeat (3) pulse_prev();
    chk("prev_to0", 32'(dispSel), 32'd0);
    pulse_prev();
    chk("wrap_dn_sel", 32'(dispSel), 32'd31);
    chk("wrap_dn_shown", shown, 32'h1000_020F);
    pulse_next();
    chk("wrap_up_sel", 32'(dispSel), 32'd0);
    chk("wrap_up_shown", shown, 32'h1000_0000);

    next = 1; prev = 1; cyc(2);
    chk("both_sel", 32'(dispSel), 32'd0);
    next = 0; prev = 0; cyc(2);

    repeat (3) pulse_next();
    cyc(8);
    freeze = 1; ovr = 1;
    cyc(64);
    chk("frozen", shown, 32'h1000_0033);
    freeze = 0;
    cyc(33);
    chk("unfrozen", shown, 32'hDEAD_BEEF);
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      chk("onehot", 32'($countones(~an)), 32'd1);
      for (int k = 0; k < 8; k++)
        if (an == ~(8'd1 << k)) chk("beef_digit", 32'(seg), 32'(beef_seg[k]));
    end

    cyc(5);
    reset = 1; cyc(1);
    chk("midrst_an", 32'(an), 32'hFE);
    chk("midrst_seg", 32'(seg), 32'h40);
    chk("midrst_sel", 32'(dispSel), 32'd0);
    reset = 0;

    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) next = ~next;
      if ($urandom_range(0, 3) == 0) prev = ~prev;
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      if ($urandom_range(0, 31) == 0) ovr = ~ovr;
      if ($urandom_range(0, 63) == 0) ovr_val = $urandom;
      reset = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 0; next = 0; prev = 0; freeze = 0;
    cyc(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
